csr_arbiter: RTL
================

CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 12'h51E, the address of the tohost CSR.
REQ-002 SHALL have parameter CNT_W, default 64, the width of the cycle and instret counters.
REQ-003 SHALL use a single clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 SHALL have: rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have: cpu_csr_en  in  1  CPU CSR instruction in execute this cycle.
REQ-006 SHALL have: cpu_csr_op  in  2  operation, 01=RW, 10=RS, 11=RC; 00 is a no-op.
REQ-007 SHALL have: cpu_csr_addr  in  12  CSR address; cpu_csr_wdata  in  32  rs1 value or zero-extended zimm.
REQ-008 SHALL have: cpu_csr_rdata  out  32  combinational old value of the addressed CSR.
REQ-009 SHALL have: instr_retire  in  1  one instruction retires this cycle.
REQ-010 SHALL have host-port inputs: host_req_valid, host_req_we (1 each), host_req_addr (12), host_req_wdata (32).
REQ-011 SHALL have host-port outputs: host_req_ready (1), host_resp_valid (1), host_resp_data (32).
REQ-012 SHALL have: tohost  out  32  current tohost register; illegal_csr  out  1  combinational flag for an illegal CPU access.

Function
REQ-013 SHALL use this CSR map: TOHOST_ADDR is read/write; 0xC00/0xC80 are cycle low/high and 0xC02/0xC82 are instret low/high, all read-only; every other address is illegal.
REQ-014 SHALL commit CPU writes at the next rising edge: RW writes wdata, RS writes old|wdata, RC writes old&~wdata.
REQ-015 SHALL perform no write for RS or RC when wdata==0, and SHALL flag no illegal access for that case.
REQ-016 SHALL handle an illegal CPU access (any write to a read-only CSR, or any access to an unmapped address) as follows: illegal_csr=1 in the same cycle, rdata=0, no state change.
REQ-017 SHALL run the host FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-018 SHALL drive host_req_ready=1 only in IDLE with cpu_csr_en=0, and SHALL latch the request on host_req_valid&host_req_ready.
REQ-019 SHALL, in WAIT, hold while cpu_csr_en=1 (CPU priority); otherwise it SHALL perform the access at the edge, capture the old value and go to RESP.
REQ-020 SHALL perform host accesses as full-word writes (RW semantics); host writes to read-only or unmapped CSRs SHALL be ignored and SHALL read 0.
REQ-021 SHALL, in RESP, assert host_resp_valid=1 for exactly one cycle with host_resp_data equal to the captured old value; the host port has no backpressure.
REQ-022 SHALL give minimum host latency of 2 cycles from the accept edge to host_resp_valid.
REQ-023 SHALL never let a host and a CPU write land on the same edge, so writes cannot collide.
REQ-024 SHALL increment cycle every clock; instret SHALL increment when instr_retire=1; both SHALL wrap 2^CNT_W-1 -> 0.
REQ-025 SHALL keep counter writes impossible, so the counters change only by increment.

Reset
REQ-026 SHALL, on rst, asynchronously set tohost=0, cycle=0, instret=0, FSM=IDLE and host_resp_valid=0.
REQ-027 SHALL abort any in-flight host transaction on reset mid-transaction, with no host_resp_valid pulse.

Configuration
REQ-028 SHALL, with CSR_COUNTERS_EN defined, implement both counters and map the four counter addresses.
REQ-029 SHALL, without CSR_COUNTERS_EN, omit both counters, and SHALL treat the four counter addresses as illegal (read 0, illegal_csr=1).

Structure
REQ-030 SHALL place the CSR address constants, the cpu_csr_op encodings and the host FSM state enum in shared package csr_pkg.
REQ-031 SHALL instantiate sub-module csr_counter (CNT_W-bit counter with enable and asynchronous reset) twice, for cycle and instret.

Verification
REQ-032 SHALL cover: RW 0x51E with wdata=100 after reset -> rdata=0, then tohost=100 one edge later.
REQ-033 SHALL cover: RS 0x51E with 0x10 -> tohost=0x74; then RC with 0x64 -> tohost=16; RS with 0 -> no change, illegal_csr=0.
REQ-034 SHALL cover: host read of 0x51E with the CPU idle -> accepted, then host_resp_valid 2 cycles later with data 16.
REQ-035 SHALL cover: host write of 5 while the CPU performs RW of 7 to 0x51E for 3 cycles -> host held in WAIT, resp data=7, final tohost=5.
REQ-036 SHALL cover: 50 cycles after reset -> read 0xC00 returns 50 with the macro defined and 0 with illegal_csr=1 without it; RW to 0xC00 -> illegal_csr=1, value unchanged.
REQ-037 SHALL cover: rst asserted while the host FSM is in WAIT -> no resp pulse, tohost=0, host_req_ready=1 after reset.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, op encodings, host FSM states and decode helpers
package csr_pkg;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_RESP = 2'd2
  } host_state_e;

  function automatic logic is_counter_addr(input logic [11:0] addr);
    return (addr == CSR_CYCLE) || (addr == CSR_CYCLEH) ||
           (addr == CSR_INSTRET) || (addr == CSR_INSTRETH);
  endfunction

  // Selects the 32-bit half of cycle/instret named by a counter address.
  function automatic logic [31:0] counter_word(input logic [11:0] addr,
                                               input logic [63:0] cyc,
                                               input logic [63:0] ins);
    case (addr)
      CSR_CYCLE:    return cyc[31:0];
      CSR_CYCLEH:   return cyc[63:32];
      CSR_INSTRET:  return ins[31:0];
      CSR_INSTRETH: return ins[63:32];
      default:      return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - free-running W-bit counter with enable, wraps to zero
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance by one when enabled; natural overflow gives the wrap.
  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + W'(1);
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_arbiter.sv
// rtl/csr_arbiter.sv - CPU/host CSR arbiter (tohost + optional counters under CSR_COUNTERS_EN)
module csr_arbiter
  import csr_pkg::*;
#(
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter int          CNT_W       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_csr_en,
  input  logic [1:0]  cpu_csr_op,
  input  logic [11:0] cpu_csr_addr,
  input  logic [31:0] cpu_csr_wdata,
  output logic [31:0] cpu_csr_rdata,
  input  logic        instr_retire,
  input  logic        host_req_valid,
  input  logic        host_req_we,
  input  logic [11:0] host_req_addr,
  input  logic [31:0] host_req_wdata,
  output logic        host_req_ready,
  output logic        host_resp_valid,
  output logic [31:0] host_resp_data,
  output logic [31:0] tohost,
  output logic        illegal_csr
);

  logic [63:0] cycle_w;
  logic [63:0] instret_w;

`ifdef CSR_COUNTERS_EN
  localparam logic CNT_EN = 1'b1;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  csr_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  csr_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .en    (instr_retire),
    .count (instret_cnt)
  );

  assign cycle_w   = 64'(cycle_cnt);
  assign instret_w = 64'(instret_cnt);
`else
  localparam logic CNT_EN = 1'b0;
  logic unused_cnt;
  assign unused_cnt = instr_retire ^ CNT_W[0];
  assign cycle_w    = 64'h0;
  assign instret_w  = 64'h0;
`endif

  host_state_e state_q, state_d;
  logic [31:0] tohost_q, tohost_d;
  logic        h_we_q, h_we_d;
  logic [11:0] h_addr_q, h_addr_d;
  logic [31:0] h_wdata_q, h_wdata_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic        cpu_is_tohost;
  logic        cpu_is_cnt;
  logic        cpu_wants_wr;
  logic        cpu_wr;
  logic [31:0] cpu_old;
  logic [31:0] cpu_new;
  logic        h_is_tohost;
  logic [31:0] host_old;

  // CPU side: decode, legality, old value and the value an RW/RS/RC would commit.
  always_comb begin
    cpu_is_tohost = (cpu_csr_addr == TOHOST_ADDR);
    cpu_is_cnt    = CNT_EN && is_counter_addr(cpu_csr_addr);
    cpu_wants_wr  = (cpu_csr_op == OP_RW) ||
                    ((cpu_csr_op != OP_NOP) && (cpu_csr_wdata != 32'h0));
    cpu_old       = cpu_is_tohost ? tohost_q :
                    (cpu_is_cnt ? counter_word(cpu_csr_addr, cycle_w, instret_w) : 32'h0);
    illegal_csr   = cpu_csr_en && (cpu_csr_op != OP_NOP) &&
                    ((!cpu_is_tohost && !cpu_is_cnt) || (!cpu_is_tohost && cpu_wants_wr));
    cpu_csr_rdata = illegal_csr ? 32'h0 : cpu_old;
    cpu_wr        = cpu_csr_en && (cpu_csr_op != OP_NOP) && cpu_is_tohost && cpu_wants_wr;
    case (cpu_csr_op)
      OP_RS:   cpu_new = cpu_old | cpu_csr_wdata;
      OP_RC:   cpu_new = cpu_old & ~cpu_csr_wdata;
      default: cpu_new = cpu_csr_wdata;
    endcase
  end

  // Host FSM and tohost update; host only touches state when the CPU is idle, so writes never collide.
  always_comb begin
    state_d        = state_q;
    tohost_d       = tohost_q;
    h_we_d         = h_we_q;
    h_addr_d       = h_addr_q;
    h_wdata_d      = h_wdata_q;
    resp_data_d    = resp_data_q;
    host_req_ready = (state_q == H_IDLE) && !cpu_csr_en;
    h_is_tohost    = (h_addr_q == TOHOST_ADDR);
    if (h_is_tohost)
      host_old = tohost_q;
    else if (!h_we_q && CNT_EN && is_counter_addr(h_addr_q))
      host_old = counter_word(h_addr_q, cycle_w, instret_w);
    else
      host_old = 32'h0;

    case (state_q)
      H_IDLE: begin
        if (host_req_valid && host_req_ready) begin
          h_we_d    = host_req_we;
          h_addr_d  = host_req_addr;
          h_wdata_d = host_req_wdata;
          state_d   = H_WAIT;
        end
      end
      H_WAIT: begin
        if (!cpu_csr_en) begin
          resp_data_d = host_old;
          if (h_we_q && h_is_tohost) tohost_d = h_wdata_q;
          state_d = H_RESP;
        end
      end
      H_RESP:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase

    if (cpu_wr) tohost_d = cpu_new;
  end

  // State registers; reset drops any in-flight host transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= H_IDLE;
      tohost_q    <= 32'h0;
      h_we_q      <= 1'b0;
      h_addr_q    <= 12'h0;
      h_wdata_q   <= 32'h0;
      resp_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      tohost_q    <= tohost_d;
      h_we_q      <= h_we_d;
      h_addr_q    <= h_addr_d;
      h_wdata_q   <= h_wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign tohost          = tohost_q;
  assign host_resp_valid = (state_q == H_RESP);
  assign host_resp_data  = resp_data_q;

endmodule
